sdspi_init_seq: RTL
===================

# sdspi_init_seq

Power-up initialisation sequencer for an SD card in SPI mode. It drives the SPI command issuer's request port (strobe, type, index, argument) and consumes its R1/R3/R7 responses. It walks the card through CMD0 → CMD8 → (CMD55/ACMD41)* → CMD58, optionally followed by CMD59. It reports card version, capacity class, OCR, and a pass/fail code to the host register layer.

## Interface
- `RETRY_LIMIT`, default 1000: maximum ACMD41 attempts before giving up.
- `RETRY_WAIT`, default 2000: idle clocks between ACMD41 attempts.
- `RESP_TIMEOUT`, default 2^20: clocks allowed from command acceptance to `i_rxvalid`.
- `i_clk`, input, 1: clock.
- `i_reset`, input, 1: reset; synchronous, active-high.
- `i_start`, input, 1: begin (or restart) initialisation.
- `o_busy`, output, 1: sequence in progress.
- `o_done`, output, 1: level; card initialised.
- `o_err`, output, 1: level; sequence failed.
- `o_err_code`, output, 4: failure cause; 0 when no error.
- `o_v2`, output, 1: card answered CMD8 (spec v2+).
- `o_hcs`, output, 1: CCS bit from OCR; high-capacity card.
- `o_ocr`, output, 32: last OCR from CMD58.
- `o_cmd_stb`, output, 1: command request pulse to the issuer.
- `o_cmd_type`, output, 2: 00 = R1, 01 = R1b, 1x = R3/R7.
- `o_cmd`, output, 6: command index.
- `o_cmd_data`, output, 32: command argument.
- `i_cmd_busy`, input, 1: issuer busy.
- `i_rxvalid`, input, 1: one-cycle response-valid pulse.
- `i_response`, input, 40: {R1, 32-bit payload}.

## Operation
- States: IDLE, CMD0, CMD8, CMD55, ACMD41, RWAIT, CMD58, CMD59, DONE, ERR.
- Each command state has two phases:
  - ISSUE: pulse `o_cmd_stb` for exactly one cycle, only while `i_cmd_busy` is low.
  - RESP: wait for `i_rxvalid`.
- Command and argument fields are stable from ISSUE until the state changes.
- Let R1 = `i_response[39:32]`.
- CMD0: arg 0, R1 type. R1 == 0x01 → CMD8. Any other value → retry once more, then ERR with code 1.
- CMD8: arg 0x000001AA, R7 type.
  - R1 == 0x01 and `i_response[11:0]` == 0x1AA → `o_v2` = 1, go to CMD55.
  - R1 == 0x05 (illegal command) → `o_v2` = 0, go to CMD55.
  - Anything else → ERR with code 2.
- CMD55: arg 0, R1 type. R1 ∈ {0x00, 0x01} → ACMD41. Otherwise ERR with code 3.
- ACMD41 (index 41): arg 0x40000000 if `o_v2`, else 0.
  - R1 == 0x00 → CMD58.
  - R1 == 0x01 → increment the attempt count. If the count equals `RETRY_LIMIT` → ERR with code 5; else → RWAIT.
  - Anything else → ERR with code 4.
- RWAIT: count `RETRY_WAIT` clocks, then → CMD55.
- CMD58: arg 0, R3 type.
  - Require R1[7:1] == 0; otherwise ERR with code 6.
  - `o_ocr` ← `i_response[31:0]`.
  - `o_hcs` ← `o_v2` & `i_response[30]`.
- CMD59: arg 1, R1 type. R1 == 0x00 → DONE; otherwise ERR with code 7.
- Response timeout: when the RESP phase exceeds `RESP_TIMEOUT` clocks → ERR with code 8.
  - The issuer is not aborted. The host must reset it together with this block before retrying.
- `i_start` is accepted in IDLE, DONE or ERR.
  - On acceptance, clear `o_done`, `o_err`, `o_err_code`, `o_v2`, `o_hcs`, `o_ocr`, and the retry count.
  - `i_start` is ignored while busy.
- `i_rxvalid` outside a RESP phase is ignored.
- `o_busy` = state ∉ {IDLE, DONE, ERR}.

## Timing
- Reset: state IDLE; all outputs 0; `o_cmd_data` = 0; `o_err_code` = 0.
- Reset mid-sequence returns to IDLE on the next edge and drops `o_cmd_stb`.
- `i_start` high at cycle N (with `i_cmd_busy` low) → `o_cmd_stb` with CMD0 at N+1, and `o_busy` at N+1.
- ISSUE with `i_cmd_busy` high: hold off, with no strobe, until it drops.
- `i_rxvalid` at cycle M → registered decision. The next `o_cmd_stb` is at M+1 (when the next state is a command state with `i_cmd_busy` low).
- DONE/ERR are entered at M+1, with `o_busy` low in the same cycle.
- RWAIT: the CMD55 strobe follows exactly `RETRY_WAIT`+1 cycles after the ACMD41 `i_rxvalid`.
- Timeout counter:
  - Loads on the strobe cycle.
  - ERR is entered on the cycle after it reaches 0 with no `i_rxvalid`.
  - `i_rxvalid` on that same final cycle wins over the timeout.

## Configuration
- `SDSPI_INIT_CRC_EN`:
  - Defined: after CMD58 the sequence issues CMD59 (arg 1), enabling card CRC checking, and reaches DONE only on R1 == 0x00.
  - Undefined: the CMD59 state is absent, CMD58 success goes directly to DONE, and error code 7 is never produced.

## Structure
- Package `sdspi_init_pkg` holds:
  - the state enum;
  - command index constants (0, 8, 55, 41, 58, 59);
  - response type codes;
  - the CMD8 check pattern 0x1AA;
  - error codes 1–8.
- One sub-module, `sdspi_init_timer`: a loadable down-counter with a zero flag, shared between RWAIT and the response timeout (the two are never active together).

## Test plan
- v2 SDHC: responses CMD0 R1 = 0x01; CMD8 {0x01, 0x000001AA}; ACMD41 R1 = 0x01 twice then 0x00; CMD58 {0x00, 0xC0FF8000}.
  - Expect `o_done` = 1, `o_v2` = 1, `o_hcs` = 1, `o_ocr` = 0xC0FF8000.
  - Expect three CMD55/ACMD41 pairs, and ACMD41 arg 0x40000000.
- v1 card: CMD8 R1 = 0x05 → ACMD41 arg 0; CMD58 OCR 0x40FF8000 → `o_hcs` = 0, `o_done` = 1.
- CMD8 echo 0x0000_01AB → `o_err` = 1, `o_err_code` = 2, no further strobes.
- ACMD41 always 0x01 with `RETRY_LIMIT` = 3 → exactly 3 ACMD41 strobes, then `o_err_code` = 5.
- No `i_rxvalid` after CMD0 with `RESP_TIMEOUT` = 16 → `o_err_code` = 8 at strobe + 17 cycles; a second `i_start` restarts from CMD0.
- `i_reset` asserted during RWAIT → IDLE next cycle, all outputs 0, no stray strobe; `i_cmd_busy` held high 5 cycles before CMD0 → strobe delayed until it drops.

Source files
------------

// File: rtl/sdspi_init_seq_pkg.sv
// sdspi_init_pkg: shared constants for the SD SPI-mode init sequencer
// Holds state encodings, command indices, response type codes, the CMD8 echo
// pattern, error codes and a helper that identifies command-issuing states.
package sdspi_init_pkg;
  localparam logic [3:0] ST_IDLE   = 4'd0;
  localparam logic [3:0] ST_CMD0   = 4'd1;
  localparam logic [3:0] ST_CMD8   = 4'd2;
  localparam logic [3:0] ST_CMD55  = 4'd3;
  localparam logic [3:0] ST_ACMD41 = 4'd4;
  localparam logic [3:0] ST_RWAIT  = 4'd5;
  localparam logic [3:0] ST_CMD58  = 4'd6;
  localparam logic [3:0] ST_CMD59  = 4'd7;
  localparam logic [3:0] ST_DONE   = 4'd8;
  localparam logic [3:0] ST_ERR    = 4'd9;
  localparam logic [5:0] CMD_GO_IDLE  = 6'd0;
  localparam logic [5:0] CMD_SEND_IF  = 6'd8;
  localparam logic [5:0] CMD_APP_CMD  = 6'd55;
  localparam logic [5:0] CMD_SEND_OP  = 6'd41;
  localparam logic [5:0] CMD_READ_OCR = 6'd58;
  localparam logic [5:0] CMD_CRC_ON   = 6'd59;
  localparam logic [1:0] RT_R1  = 2'b00;
  localparam logic [1:0] RT_R37 = 2'b10;
  localparam logic [11:0] CHECK_PATTERN = 12'h1AA;
  localparam logic [3:0] E_NONE    = 4'd0;
  localparam logic [3:0] E_CMD0    = 4'd1;
  localparam logic [3:0] E_CMD8    = 4'd2;
  localparam logic [3:0] E_CMD55   = 4'd3;
  localparam logic [3:0] E_ACMD41  = 4'd4;
  localparam logic [3:0] E_RETRY   = 4'd5;
  localparam logic [3:0] E_CMD58   = 4'd6;
  localparam logic [3:0] E_CMD59   = 4'd7;
  localparam logic [3:0] E_TIMEOUT = 4'd8;
  function automatic logic is_cmd_state(input logic [3:0] s);
    return s inside {ST_CMD0, ST_CMD8, ST_CMD55, ST_ACMD41, ST_CMD58, ST_CMD59};
  endfunction
endpackage

// File: rtl/sdspi_init_seq_timer.sv
// sdspi_init_timer: loadable down-counter with zero flag
// Ports: i_clk, i_reset (sync, active-high), i_load/i_value load the count,
// o_zero is high while the count is zero. The count saturates at zero.
module sdspi_init_timer #(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_load,
  input  logic [W-1:0] i_value,
  output logic         o_zero
);
  logic [W-1:0] cnt;
  always_ff @(posedge i_clk) begin
    if (i_reset) cnt <= '0;
    else if (i_load) cnt <= i_value;
    else if (cnt != '0) cnt <= cnt - 1'b1;
  end
  assign o_zero = cnt == '0;
endmodule

// File: rtl/sdspi_init_seq.sv
// sdspi_init_seq: SD card SPI-mode power-up sequencer (CMD0, CMD8, CMD55/ACMD41 loop, CMD58, optional CMD59)
// Ports: i_clk/i_reset (sync, active-high); i_start begins init from IDLE/DONE/ERR;
// o_busy/o_done/o_err/o_err_code report progress; o_v2/o_hcs/o_ocr report the card;
// o_cmd_stb/o_cmd_type/o_cmd/o_cmd_data drive the command issuer, which answers via
// i_cmd_busy, i_rxvalid and i_response ({R1, 32-bit payload}).
// Define SDSPI_INIT_CRC_EN to append CMD59 (CRC on) after CMD58.
module sdspi_init_seq
  import sdspi_init_pkg::*;
#(
  parameter int RETRY_LIMIT  = 1000,
  parameter int RETRY_WAIT   = 2000,
  parameter int RESP_TIMEOUT = 1 << 20
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic [3:0]  o_err_code,
  output logic        o_v2,
  output logic        o_hcs,
  output logic [31:0] o_ocr,
  output logic        o_cmd_stb,
  output logic [1:0]  o_cmd_type,
  output logic [5:0]  o_cmd,
  output logic [31:0] o_cmd_data,
  input  logic        i_cmd_busy,
  input  logic        i_rxvalid,
  input  logic [39:0] i_response
);
  localparam logic [31:0] TMO_LOAD  = 32'(RESP_TIMEOUT);
  localparam logic [31:0] WAIT_LOAD = RETRY_WAIT > 0 ? 32'(RETRY_WAIT - 1) : 32'd0;
  logic [3:0]  state, nxt, ecode;
  logic        launch, pend, cmd0_retry, resp, stb_now, t_zero, t_load;
  logic [31:0] tries, t_value;
  logic [7:0]  r1;
  logic        r1_ok8;
  assign r1 = i_response[39:32];
  assign r1_ok8 = r1 == 8'h01 && i_response[11:0] == CHECK_PATTERN;
  // RESP phase: in a command state once the strobe has gone out
  assign resp = is_cmd_state(state) && !pend;
  assign o_busy = !(state == ST_IDLE || state == ST_DONE || state == ST_ERR);
  assign o_done = state == ST_DONE;
  assign o_err = state == ST_ERR;
  assign o_cmd = state == ST_CMD8   ? CMD_SEND_IF  :
                 state == ST_CMD55  ? CMD_APP_CMD  :
                 state == ST_ACMD41 ? CMD_SEND_OP  :
                 state == ST_CMD58  ? CMD_READ_OCR :
                 state == ST_CMD59  ? CMD_CRC_ON   : CMD_GO_IDLE;
  assign o_cmd_type = (state == ST_CMD8 || state == ST_CMD58) ? RT_R37 : RT_R1;
  assign o_cmd_data = state == ST_CMD8   ? {20'h0, CHECK_PATTERN} :
                      state == ST_ACMD41 ? (o_v2 ? 32'h4000_0000 : 32'h0) :
                      state == ST_CMD59  ? 32'h1 : 32'h0;
  // A command strobes on entry if the issuer is free, otherwise it is held pending
  assign stb_now = (launch || pend) && !i_cmd_busy;
  assign t_load = stb_now || (nxt == ST_RWAIT && state != ST_RWAIT);
  assign t_value = stb_now ? TMO_LOAD : WAIT_LOAD;
  always_comb begin
    nxt = state;
    launch = 1'b0;
    ecode = E_NONE;
    if (!o_busy) begin
      if (i_start) begin
        nxt = ST_CMD0;
        launch = 1'b1;
      end
    end else if (state == ST_RWAIT) begin
      if (t_zero) begin
        nxt = ST_CMD55;
        launch = 1'b1;
      end
    end else if (resp && i_rxvalid) begin
      case (state)
        ST_CMD0: begin
          if (r1 == 8'h01) begin
            nxt = ST_CMD8;
            launch = 1'b1;
          end else if (!cmd0_retry) begin
            launch = 1'b1;
          end else ecode = E_CMD0;
        end
        ST_CMD8: begin
          if (r1_ok8 || r1 == 8'h05) begin
            nxt = ST_CMD55;
            launch = 1'b1;
          end else ecode = E_CMD8;
        end
        ST_CMD55: begin
          if (r1[7:1] == 7'h0) begin
            nxt = ST_ACMD41;
            launch = 1'b1;
          end else ecode = E_CMD55;
        end
        ST_ACMD41: begin
          if (r1 == 8'h00) begin
            nxt = ST_CMD58;
            launch = 1'b1;
          end else if (r1 == 8'h01) begin
            if (tries + 32'd1 == 32'(RETRY_LIMIT)) ecode = E_RETRY;
            else nxt = ST_RWAIT;
          end else ecode = E_ACMD41;
        end
        ST_CMD58: begin
          if (r1[7:1] != 7'h0) ecode = E_CMD58;
`ifdef SDSPI_INIT_CRC_EN
          else begin
            nxt = ST_CMD59;
            launch = 1'b1;
          end
`else
          else nxt = ST_DONE;
`endif
        end
`ifdef SDSPI_INIT_CRC_EN
        ST_CMD59: begin
          if (r1 == 8'h00) nxt = ST_DONE;
          else ecode = E_CMD59;
        end
`endif
        default: ;
      endcase
    end else if (resp && t_zero) begin
      ecode = E_TIMEOUT;
    end
    if (ecode != E_NONE) begin
      nxt = ST_ERR;
      launch = 1'b0;
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= ST_IDLE;
      pend <= 1'b0;
      o_cmd_stb <= 1'b0;
      cmd0_retry <= 1'b0;
      tries <= '0;
      o_v2 <= 1'b0;
      o_hcs <= 1'b0;
      o_ocr <= '0;
      o_err_code <= E_NONE;
    end else begin
      state <= nxt;
      o_cmd_stb <= stb_now;
      pend <= (launch || pend) && i_cmd_busy;
      if (!o_busy && i_start) begin
        cmd0_retry <= 1'b0;
        tries <= '0;
        o_v2 <= 1'b0;
        o_hcs <= 1'b0;
        o_ocr <= '0;
        o_err_code <= E_NONE;
      end
      if (resp && i_rxvalid) begin
        if (state == ST_CMD0) cmd0_retry <= 1'b1;
        if (state == ST_CMD8) o_v2 <= r1_ok8;
        if (state == ST_ACMD41 && r1 == 8'h01) tries <= tries + 32'd1;
        if (state == ST_CMD58 && r1[7:1] == 7'h0) begin
          o_ocr <= i_response[31:0];
          o_hcs <= o_v2 & i_response[30];
        end
      end
      if (ecode != E_NONE) o_err_code <= ecode;
    end
  end
  sdspi_init_timer #(.W(32)) u_timer (
    .i_clk(i_clk),
    .i_reset(i_reset),
    .i_load(t_load),
    .i_value(t_value),
    .o_zero(t_zero)
  );
endmodule
